uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 41 ++++
 rtl/uart_sync_fifo.sv | 62 ++++++
 rtl/uart_tx_fifo.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam int MAX_DATA_BITS = 8;

  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data, input int mode);
    if (mode == int'(PAR_ODD)) begin
      return ~(^data);
    end else begin
      return ^data;
    end
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes into a full FIFO are dropped.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign rd_data   = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO front end feeding a frame serialiser.
module uart_tx_fifo import uart_pkg::*; #(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic [DATA_BITS-1:0]        din,
  input  logic                        din_valid,
  output logic                        din_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int TW  = cnt_width(DIV);

  generate
    if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
      $error("uart_tx_fifo: illegal parameter set");
    end
  endgenerate

  state_e               state_r;
  logic [TW-1:0]        tick_r;
  logic [2:0]           bit_idx_r;
  logic [DATA_BITS-1:0] shreg_r;
  logic                 par_r;
  logic                 tx_r;
  logic                 busy_r;

  logic [DATA_BITS-1:0] fifo_rdata_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic                 pop_s;
  logic                 bit_end_s;
  logic                 last_stop_s;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .push    (din_valid),
    .wr_data (din),
    .pop     (pop_s),
    .rd_data (fifo_rdata_s),
    .count   (fifo_count),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  assign din_ready   = !fifo_full_s;
  assign tx          = tx_r;
  assign busy        = busy_r;
  assign bit_end_s   = (tick_r == TW'(DIV - 1));
  assign last_stop_s = (bit_idx_r == 3'(STOP_BITS - 1));
  // A new word is taken either from idle or back-to-back at the end of the last stop bit.
  assign pop_s = !fifo_empty_s &&
                 ((state_r == ST_IDLE) ||
                  ((state_r == ST_STOP) && bit_end_s && last_stop_s));

  // Frame serialiser: one state per bit class, tick counter times each bit.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r   <= ST_IDLE;
      tick_r    <= '0;
      bit_idx_r <= 3'd0;
      shreg_r   <= '0;
      par_r     <= 1'b0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            state_r <= ST_START;
            tick_r  <= '0;
            shreg_r <= fifo_rdata_s;
            par_r   <= calc_parity(MAX_DATA_BITS'(fifo_rdata_s), PARITY);
            tx_r    <= 1'b0;
            busy_r  <= 1'b1;
          end else begin
            tx_r   <= 1'b1;
            busy_r <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end_s) begin
            state_r   <= ST_DATA;
            tick_r    <= '0;
            bit_idx_r <= 3'd0;
            tx_r      <= shreg_r[0];
          end else begin
            tick_r <= tick_r + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end_s) begin
            tick_r <= '0;
            if (bit_idx_r == 3'(DATA_BITS - 1)) begin
              bit_idx_r <= 3'd0;
              if (PARITY != 0) begin
                state_r <= ST_PARITY;
                tx_r    <= par_r;
              end else begin
                state_r <= ST_STOP;
                tx_r    <= 1'b1;
              end
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              shreg_r   <= shreg_r >> 1;
              tx_r      <= shreg_r[1];
            end
          end else begin
            tick_r <= tick_r + 1'b1;
          end
        end
        ST_PARITY: begin
          if (bit_end_s) begin
            state_r   <= ST_STOP;
            tick_r    <= '0;
            bit_idx_r <= 3'd0;
            tx_r      <= 1'b1;
          end else begin
            tick_r <= tick_r + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end_s) begin
            tick_r <= '0;
            if (!last_stop_s) begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end else if (pop_s) begin
              state_r   <= ST_START;
              bit_idx_r <= 3'd0;
              shreg_r   <= fifo_rdata_s;
              par_r     <= calc_parity(MAX_DATA_BITS'(fifo_rdata_s), PARITY);
              tx_r      <= 1'b0;
            end else begin
              state_r   <= ST_IDLE;
              bit_idx_r <= 3'd0;
              tx_r      <= 1'b1;
              busy_r    <= 1'b0;
            end
          end else begin
            tick_r <= tick_r + 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          tick_r  <= '0;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule
